lorenz_plotter: RTL and testbench
=================================

Name: lorenz_plotter

Overview:
Downstream consumer of the Lorenz ODE solver's 27-bit signed 7.20 state outputs x, y and z.
- Accepts one (x, y, z) sample per valid/ready handshake.
- Projects it onto three side-by-side screen panels: XY, YZ and XZ.
- Issues up to three single-pixel writes to the VGA framebuffer arbiter over a req/ack handshake.
- Owns framebuffer clearing after reset and on request.

Parameters:
H_RES, 640, framebuffer width in pixels (row stride)
V_RES, 480, framebuffer height in pixels
PANEL_W, 212, width of each panel; panel i has its left edge at i*PANEL_W
PANEL_H, 240, height of each panel
PANEL_Y0, 120, top row shared by all panels
PIX_SHIFT, 18, arithmetic right shift from 7.20 value to pixel offset (1.0 = 4 px)
Z_OFFSET, 27'sd26214400, value subtracted from z before mapping (25.0 in 7.20)
COLOR_XY / COLOR_YZ / COLOR_XZ, 8'hE0 / 8'h1C / 8'h03, pixel colour written for each panel

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
x_in  in  27  signed 7.20 state x from the solver
y_in  in  27  signed 7.20 state y
z_in  in  27  signed 7.20 state z
sample_valid  in  1  a sample is present on x_in/y_in/z_in
sample_ready  out  1  block can accept a sample
clear_start  in  1  one-cycle pulse; requests a full framebuffer clear
fb_req  out  1  framebuffer write request
fb_ack  in  1  arbiter accepts the write in this cycle
fb_addr  out  19  pixel address, computed as py*H_RES + px
fb_data  out  8  pixel colour
busy  out  1  high in every state except IDLE
drop_cnt  out  16  saturating count of clipped (unwritten) pixels

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high. Every output is registered.
- Values after the reset edge:
  - State is CLEAR and the clear address is 0.
  - fb_req=0, fb_addr=0, fb_data=0, sample_ready=0, busy=1, drop_cnt=0.
- Reset asserted mid-operation: any write in flight is abandoned without waiting for fb_ack, the captured sample is discarded, and the block restarts CLEAR from address 0.
- States: CLEAR, IDLE, MAP, WR_XY, WR_YZ, WR_XZ.
- CLEAR:
  - Writes colour 0 to addresses 0 through H_RES*V_RES-1, one write per acknowledged request.
  - After the last ack it moves to IDLE.
  - fb_req first goes high in the cycle after reset deasserts.
- IDLE:
  - sample_ready=1.
  - If sample_valid is high, the sample is captured and the state goes to MAP.
  - Otherwise, if clear_start is high, the state goes to CLEAR with address 0.
  - If sample_valid and clear_start are high together, the sample wins and the clear_start pulse is dropped.
  - clear_start is ignored in every state other than IDLE.
- sample_ready is 0 in all states except IDLE.
- MAP takes one cycle and registers, for each panel:
  - h_off = h >>> PIX_SHIFT and v_off = v >>> PIX_SHIFT (arithmetic shifts).
  - Axis pairs (h, v) are: XY = (x, y); YZ = (y, z - Z_OFFSET); XZ = (x, z - Z_OFFSET).
  - px = i*PANEL_W + PANEL_W/2 + h_off.
  - py = PANEL_Y0 + PANEL_H/2 - v_off (positive values plot upward).
  - A panel is clipped if px or py falls outside that panel's own box.
  - Perform the arithmetic in at least 28 bits so the shift and add cannot overflow.
  - Compute the address using shifts and adds only; no hardware multiplier.
- WR_XY, WR_YZ, WR_XZ (visited in that order):
  - If the panel is not clipped, fb_req=1 with a stable fb_addr and fb_data until fb_ack is sampled high, then the state advances.
  - If the panel is clipped, the state spends one cycle with fb_req=0, drop_cnt increments (saturating at 16'hFFFF), and the state advances.
  - WR_XZ returns to IDLE.
- Handshake rules:
  - A transfer completes on any edge where fb_req and fb_ack are both high.
  - fb_ack while fb_req=0 is ignored.
  - fb_req may reassert in the cycle immediately after a completed transfer.
- Latency and throughput:
  - A sample accepted at edge N gives fb_req for XY high during cycle N+1→N+2, i.e. after MAP.
  - With fb_ack tied high, a sample is processed every 5 cycles.

Decomposition:
- Package lorenz_plot_pkg holds:
  - Fixed-point constants: WIDTH=27, FRAC_BITS=20.
  - The state enum.
  - An address-width function based on clog2(H_RES*V_RES).
- Sub-module lorenz_pixel_map:
  - Inputs: h, v and the panel origin.
  - Outputs: px, py, clipped flag and fb_addr.
  - Instantiated three times and registered in MAP.

Test Plan:
- Reset with H_RES=8, V_RES=4, fb_ack=1 → exactly 32 writes of data 0 to addresses 0–31 in order, then busy=0 and sample_ready=1.
- Defaults with the clear complete; sample x=0, y=0, z=25.0 → writes 153706/E0, 153918/1C, 154130/03 in that order; drop_cnt=0.
- Sample x=1.0, y=-1.0, z=25.0 → XY pixel (110,244) at address 156270; YZ pixel (314,240) at address 153914; XZ pixel (110+424=534,240) at address 154134.
- Sample x=30.0, y=0, z=25.0 → XY and XZ clipped (px=226 exceeds 211), only the YZ write at 153918 is issued, drop_cnt=2.
- fb_ack held low for 10 cycles during WR_XY → fb_req, fb_addr and fb_data stay stable throughout and sample_ready=0; clear_start pulsed in that window is ignored.
- Reset asserted while in WR_YZ with fb_req high → fb_req=0 on the next edge and a new clear starts from address 0.

Source files
------------

// File: rtl/lorenz_plotter_pkg.sv
// Shared constants, state encoding and helpers for the Lorenz attractor plotter.
package lorenz_plot_pkg;
  localparam int WIDTH     = 27;
  localparam int FRAC_BITS = 20;
  localparam int CALC_W    = 28;

  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;
  localparam int PANEL_W   = 212;
  localparam int PANEL_H   = 240;
  localparam int PANEL_Y0  = 120;
  localparam int PIX_SHIFT = 18;

  localparam logic signed [CALC_W-1:0] Z_OFFSET = 28'sd26214400;

  localparam logic [7:0] COLOR_XY = 8'hE0;
  localparam logic [7:0] COLOR_YZ = 8'h1C;
  localparam logic [7:0] COLOR_XZ = 8'h03;

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_IDLE  = 3'd1,
    ST_MAP   = 3'd2,
    ST_WR_XY = 3'd3,
    ST_WR_YZ = 3'd4,
    ST_WR_XZ = 3'd5
  } state_e;

  function automatic int addr_width(input int pixels);
    return $clog2(pixels);
  endfunction

  localparam int ADDR_W = addr_width(H_RES_DEF * V_RES_DEF);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/lorenz_plotter_if.sv
// Sample input handshake plus framebuffer write port; master is the plotter side.
interface lorenz_plotter_if;
  import lorenz_plot_pkg::*;

  logic signed [WIDTH-1:0] x_in;
  logic signed [WIDTH-1:0] y_in;
  logic signed [WIDTH-1:0] z_in;
  logic                    sample_valid;
  logic                    sample_ready;
  logic                    fb_req;
  logic                    fb_ack;
  logic [ADDR_W-1:0]       fb_addr;
  logic [7:0]              fb_data;

  modport master (
    input  x_in, y_in, z_in, sample_valid, fb_ack,
    output sample_ready, fb_req, fb_addr, fb_data
  );

  modport slave (
    output x_in, y_in, z_in, sample_valid, fb_ack,
    input  sample_ready, fb_req, fb_addr, fb_data
  );
endinterface

// File: rtl/lorenz_plotter_pixel_map.sv
// Maps one (h, v) fixed-point pair onto a panel: clip test and linear framebuffer address.
module lorenz_pixel_map
  import lorenz_plot_pkg::*;
#(
  parameter int H_RES = 640
) (
  input  logic signed [CALC_W-1:0] i_h,
  input  logic signed [CALC_W-1:0] i_v,
  input  logic [9:0]               i_org_x,
  output logic                     o_clipped,
  output logic [ADDR_W-1:0]        o_addr
);
  logic signed [CALC_W-1:0] w_org;
  logic signed [CALC_W-1:0] w_h_off;
  logic signed [CALC_W-1:0] w_v_off;
  logic signed [CALC_W-1:0] w_px;
  logic signed [CALC_W-1:0] w_py;
  logic [ADDR_W-1:0]        w_py_a;
  logic [ADDR_W-1:0]        w_addr;

  assign w_org   = $signed({18'd0, i_org_x});
  assign w_h_off = i_h >>> PIX_SHIFT;
  assign w_v_off = i_v >>> PIX_SHIFT;
  assign w_px    = w_org + CALC_W'(PANEL_W / 2) + w_h_off;
  // Screen rows grow downward, so a positive v moves the pixel up.
  assign w_py    = CALC_W'(PANEL_Y0 + PANEL_H / 2) - w_v_off;

  assign o_clipped = (w_px < w_org) || (w_px > w_org + CALC_W'(PANEL_W - 1)) ||
                     (w_py < CALC_W'(PANEL_Y0)) || (w_py > CALC_W'(PANEL_Y0 + PANEL_H - 1));

  assign w_py_a = w_py[ADDR_W-1:0];

  // py*H_RES built from the set bits of H_RES, so only shifted adds are generated.
  always_comb begin
    w_addr = '0;
    for (int b = 0; b < 16; b++) begin
      w_addr = w_addr + (H_RES[b] ? (w_py_a << b) : {ADDR_W{1'b0}});
    end
    w_addr = w_addr + w_px[ADDR_W-1:0];
  end

  assign o_addr = w_addr;
endmodule

// File: rtl/lorenz_plotter.sv
// Plots Lorenz solver samples into XY/YZ/XZ panels and clears the framebuffer on demand.
module lorenz_plotter
  import lorenz_plot_pkg::*;
#(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic             i_clk,
  input  logic             i_reset,
  lorenz_plotter_if.master bus,
  input  logic             i_clear_start,
  output logic             o_busy,
  output logic [15:0]      o_drop_cnt
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

  state_e                  r_state;
  logic                    r_fb_req;
  logic [ADDR_W-1:0]       r_fb_addr;
  logic [7:0]              r_fb_data;
  logic                    r_ready;
  logic                    r_busy;
  logic [15:0]             r_drop_cnt;
  logic signed [WIDTH-1:0] r_x;
  logic signed [WIDTH-1:0] r_y;
  logic signed [WIDTH-1:0] r_z;
  logic [2:0]              r_clip;
  logic [ADDR_W-1:0]       r_addr_yz;
  logic [ADDR_W-1:0]       r_addr_xz;

  logic signed [CALC_W-1:0] w_x;
  logic signed [CALC_W-1:0] w_y;
  logic signed [CALC_W-1:0] w_zc;
  logic                     w_clip_xy, w_clip_yz, w_clip_xz;
  logic [ADDR_W-1:0]        w_addr_xy, w_addr_yz, w_addr_xz;
  logic                     w_done;

  assign w_x  = CALC_W'(r_x);
  assign w_y  = CALC_W'(r_y);
  assign w_zc = CALC_W'(r_z) - Z_OFFSET;

  lorenz_pixel_map #(.H_RES(H_RES)) u_map_xy (
    .i_h(w_x), .i_v(w_y), .i_org_x(10'd0),
    .o_clipped(w_clip_xy), .o_addr(w_addr_xy)
  );
  lorenz_pixel_map #(.H_RES(H_RES)) u_map_yz (
    .i_h(w_y), .i_v(w_zc), .i_org_x(10'(PANEL_W)),
    .o_clipped(w_clip_yz), .o_addr(w_addr_yz)
  );
  lorenz_pixel_map #(.H_RES(H_RES)) u_map_xz (
    .i_h(w_x), .i_v(w_zc), .i_org_x(10'(2 * PANEL_W)),
    .o_clipped(w_clip_xz), .o_addr(w_addr_xz)
  );

  assign w_done = r_fb_req && bus.fb_ack;

  // Main controller: clear sweep, sample capture, mapping and the three panel writes.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_CLEAR;
      r_fb_req   <= 1'b0;
      r_fb_addr  <= '0;
      r_fb_data  <= 8'h00;
      r_ready    <= 1'b0;
      r_busy     <= 1'b1;
      r_drop_cnt <= 16'h0000;
      r_x        <= '0;
      r_y        <= '0;
      r_z        <= '0;
      r_clip     <= 3'b000;
      r_addr_yz  <= '0;
      r_addr_xz  <= '0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (w_done) begin
            if (r_fb_addr == LAST_ADDR) begin
              r_state  <= ST_IDLE;
              r_fb_req <= 1'b0;
              r_ready  <= 1'b1;
              r_busy   <= 1'b0;
            end else begin
              r_fb_addr <= r_fb_addr + ADDR_W'(1);
            end
          end else begin
            r_fb_req <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (bus.sample_valid) begin
            r_x     <= bus.x_in;
            r_y     <= bus.y_in;
            r_z     <= bus.z_in;
            r_state <= ST_MAP;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end else if (i_clear_start) begin
            r_state   <= ST_CLEAR;
            r_fb_addr <= '0;
            r_fb_data <= 8'h00;
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
          end else begin
            r_ready <= 1'b1;
          end
        end
        ST_MAP: begin
          r_clip    <= {w_clip_xz, w_clip_yz, w_clip_xy};
          r_addr_yz <= w_addr_yz;
          r_addr_xz <= w_addr_xz;
          r_fb_addr <= w_addr_xy;
          r_fb_data <= COLOR_XY;
          r_fb_req  <= !w_clip_xy;
          r_state   <= ST_WR_XY;
        end
        ST_WR_XY: begin
          if (r_clip[0] || w_done) begin
            r_drop_cnt <= r_clip[0] ? sat_inc16(r_drop_cnt) : r_drop_cnt;
            r_fb_addr  <= r_addr_yz;
            r_fb_data  <= COLOR_YZ;
            r_fb_req   <= !r_clip[1];
            r_state    <= ST_WR_YZ;
          end
        end
        ST_WR_YZ: begin
          if (r_clip[1] || w_done) begin
            r_drop_cnt <= r_clip[1] ? sat_inc16(r_drop_cnt) : r_drop_cnt;
            r_fb_addr  <= r_addr_xz;
            r_fb_data  <= COLOR_XZ;
            r_fb_req   <= !r_clip[2];
            r_state    <= ST_WR_XZ;
          end
        end
        ST_WR_XZ: begin
          if (r_clip[2] || w_done) begin
            r_drop_cnt <= r_clip[2] ? sat_inc16(r_drop_cnt) : r_drop_cnt;
            r_fb_req   <= 1'b0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          r_state   <= ST_CLEAR;
          r_fb_req  <= 1'b0;
          r_fb_addr <= '0;
          r_fb_data <= 8'h00;
          r_ready   <= 1'b0;
          r_busy    <= 1'b1;
        end
      endcase
    end
  end

  assign bus.fb_req       = r_fb_req;
  assign bus.fb_addr      = r_fb_addr;
  assign bus.fb_data      = r_fb_data;
  assign bus.sample_ready = r_ready;
  assign o_busy           = r_busy;
  assign o_drop_cnt       = r_drop_cnt;
endmodule

// File: tb/tb_lorenz_plotter.sv
// Directed bench: a tiny 8x4 instance for the clear sweep, and a 640-wide instance
// (only 4 rows tall so its clear stays short) for mapping, clipping, stall and reset.
module tb_lorenz_plotter;
  import lorenz_plot_pkg::*;

  localparam logic signed [26:0] ONE  = 27'sd1048576;
  localparam logic signed [26:0] MONE = -27'sd1048576;
  localparam logic signed [26:0] Z25  = 27'sd26214400;
  localparam logic signed [26:0] X30  = 27'sd31457280;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr_m, clr_s;
  logic        busy_m, busy_s;
  logic [15:0] drop_m, drop_s;
  int          n_vec = 0;
  int          n_bad = 0;
  logic [26:0] q_m[$];
  logic [26:0] q_s[$];

  always #5 clk = ~clk;

  lorenz_plotter_if if_m ();
  lorenz_plotter_if if_s ();

  lorenz_plotter #(.H_RES(640), .V_RES(4)) u_dut (
    .i_clk(clk), .i_reset(rst), .bus(if_m), .i_clear_start(clr_m),
    .o_busy(busy_m), .o_drop_cnt(drop_m)
  );

  lorenz_plotter #(.H_RES(8), .V_RES(4)) u_small (
    .i_clk(clk), .i_reset(rst), .bus(if_s), .i_clear_start(clr_s),
    .o_busy(busy_s), .o_drop_cnt(drop_s)
  );

  always @(posedge clk) begin
    if (if_m.fb_req && if_m.fb_ack) q_m.push_back({if_m.fb_addr, if_m.fb_data});
    if (if_s.fb_req && if_s.fb_ack) q_s.push_back({if_s.fb_addr, if_s.fb_data});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input int limit);
    int k = 0;
    while (busy_m !== 1'b0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    check("wait_idle", 32'(busy_m), 32'd0);
  endtask

  task automatic wait_req(input int limit);
    int k = 0;
    while (if_m.fb_req !== 1'b1 && k < limit) begin
      @(negedge clk);
      k++;
    end
    check("wait_req", 32'(if_m.fb_req), 32'd1);
  endtask

  task automatic expect_wr(input string tag, input logic [18:0] a, input logic [7:0] d);
    logic [26:0] e;
    e = (q_m.size() > 0) ? q_m.pop_front() : 27'h7FFFFFF;
    check(tag, 32'(e), 32'({a, d}));
  endtask

  // Returns on the negedge right after the accepting clock edge.
  task automatic send(input logic signed [26:0] x, input logic signed [26:0] y,
                      input logic signed [26:0] z);
    int k = 0;
    while (if_m.sample_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if_m.x_in = x;
    if_m.y_in = y;
    if_m.z_in = z;
    if_m.sample_valid = 1'b1;
    @(negedge clk);
    if_m.sample_valid = 1'b0;
  endtask

  initial begin
    int bad;
    rst = 1'b1;
    clr_m = 1'b0;
    clr_s = 1'b0;
    if_m.x_in = '0; if_m.y_in = '0; if_m.z_in = '0;
    if_m.sample_valid = 1'b0;
    if_m.fb_ack = 1'b1;
    if_s.x_in = '0; if_s.y_in = '0; if_s.z_in = '0;
    if_s.sample_valid = 1'b0;
    if_s.fb_ack = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_req",   32'(if_m.fb_req),       32'd0);
    check("rst_addr",  32'(if_m.fb_addr),      32'd0);
    check("rst_data",  32'(if_m.fb_data),      32'd0);
    check("rst_ready", 32'(if_m.sample_ready), 32'd0);
    check("rst_busy",  32'(busy_m),            32'd1);
    check("rst_drop",  32'(drop_m),            32'd0);

    rst = 1'b0;
    @(negedge clk);
    check("clr_first_req",  32'(if_m.fb_req),  32'd1);
    check("clr_first_addr", 32'(if_m.fb_addr), 32'd0);

    for (int k = 0; k < 100 && busy_s !== 1'b0; k++) @(negedge clk);
    check("small_busy",  32'(busy_s),            32'd0);
    check("small_ready", 32'(if_s.sample_ready), 32'd1);
    check("small_count", 32'(q_s.size()),        32'd32);
    bad = 0;
    for (int i = 0; i < q_s.size(); i++) if (q_s[i] !== {19'(i), 8'h00}) bad++;
    check("small_order", 32'(bad), 32'd0);

    wait_idle(3000);
    check("main_clr_count", 32'(q_m.size()), 32'd2560);
    bad = 0;
    for (int i = 0; i < q_m.size(); i++) if (q_m[i] !== {19'(i), 8'h00}) bad++;
    check("main_clr_order", 32'(bad), 32'd0);
    check("main_ready", 32'(if_m.sample_ready), 32'd1);
    q_m.delete();

    // Centre sample, also pinning latency and the 5-cycle turnaround.
    send(27'sd0, 27'sd0, Z25);
    check("map_req",   32'(if_m.fb_req),       32'd0);
    check("map_busy",  32'(busy_m),            32'd1);
    check("map_ready", 32'(if_m.sample_ready), 32'd0);
    @(negedge clk);
    check("xy_req",  32'(if_m.fb_req),  32'd1);
    check("xy_addr", 32'(if_m.fb_addr), 32'd153706);
    check("xy_data", 32'(if_m.fb_data), 32'hE0);
    repeat (2) @(negedge clk);
    check("xz_busy", 32'(busy_m), 32'd1);
    @(negedge clk);
    check("done_busy",  32'(busy_m),            32'd0);
    check("done_ready", 32'(if_m.sample_ready), 32'd1);
    check("v1_count", 32'(q_m.size()), 32'd3);
    expect_wr("v1_xy", 19'd153706, 8'hE0);
    expect_wr("v1_yz", 19'd153918, 8'h1C);
    expect_wr("v1_xz", 19'd154130, 8'h03);
    check("v1_drop", 32'(drop_m), 32'd0);

    send(ONE, MONE, Z25);
    wait_idle(20);
    check("v2_count", 32'(q_m.size()), 32'd3);
    expect_wr("v2_xy", 19'd156270, 8'hE0);
    expect_wr("v2_yz", 19'd153914, 8'h1C);
    expect_wr("v2_xz", 19'd154134, 8'h03);

    send(X30, 27'sd0, Z25);
    wait_idle(20);
    check("v3_count", 32'(q_m.size()), 32'd1);
    expect_wr("v3_yz", 19'd153918, 8'h1C);
    check("v3_drop", 32'(drop_m), 32'd2);

    // Ten-cycle stall in WR_XY with a clear_start pulse that must be ignored.
    if_m.fb_ack = 1'b0;
    send(27'sd0, 27'sd0, Z25);
    wait_req(5);
    for (int i = 0; i < 10; i++) begin
      check("stall_req",   32'(if_m.fb_req),       32'd1);
      check("stall_addr",  32'(if_m.fb_addr),      32'd153706);
      check("stall_data",  32'(if_m.fb_data),      32'hE0);
      check("stall_ready", 32'(if_m.sample_ready), 32'd0);
      clr_m = (i == 3);
      @(negedge clk);
    end
    clr_m = 1'b0;
    if_m.fb_ack = 1'b1;
    wait_idle(20);
    check("stall_count", 32'(q_m.size()), 32'd3);
    expect_wr("stall_xy", 19'd153706, 8'hE0);
    expect_wr("stall_yz", 19'd153918, 8'h1C);
    expect_wr("stall_xz", 19'd154130, 8'h03);
    repeat (3) @(negedge clk);
    check("no_clear_busy", 32'(busy_m),      32'd0);
    check("no_clear_wr",   32'(q_m.size()),  32'd0);

    // Reset while WR_YZ holds a request.
    if_m.fb_ack = 1'b0;
    send(ONE, MONE, Z25);
    wait_req(5);
    if_m.fb_ack = 1'b1;
    @(negedge clk);
    if_m.fb_ack = 1'b0;
    check("yz_req",  32'(if_m.fb_req),  32'd1);
    check("yz_addr", 32'(if_m.fb_addr), 32'd153914);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_req",   32'(if_m.fb_req),       32'd0);
    check("mid_rst_addr",  32'(if_m.fb_addr),      32'd0);
    check("mid_rst_busy",  32'(busy_m),            32'd1);
    check("mid_rst_ready", 32'(if_m.sample_ready), 32'd0);
    check("mid_rst_drop",  32'(drop_m),            32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("restart_req",  32'(if_m.fb_req),  32'd1);
    check("restart_addr", 32'(if_m.fb_addr), 32'd0);
    check("mid_count", 32'(q_m.size()), 32'd1);
    expect_wr("mid_xy", 19'd156270, 8'hE0);
    if_m.fb_ack = 1'b1;
    repeat (4) @(negedge clk);
    check("restart_addr4", 32'(if_m.fb_addr), 32'd4);
    check("small_drop", 32'(drop_s), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
